uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver that sits directly downstream of the enable-driven baud counter. It consumes a one-clock sample tick at OVS× the baud rate, built from the counter's wrap, e.g. counter MAX=651 at 100 MHz gives 16×9600. It deserialises LSB-first 8N1 frames from the asynchronous `rx` line and presents each byte with a one-cycle done strobe and a framing-error flag.

## Interface
- `DBIT`, default 8: data bits per frame.
- `OVS`, default 16: sample ticks per bit; a power of two, ≥ 4.
- `SB_TICK`, default 16: sample ticks spent in the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
- `clk` input, 1: system clock; all state updates on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `s_tick` input, 1: sample tick, high for exactly one `clk` cycle per period, from the baud counter.
- `rx` input, 1: serial line, idle high, asynchronous to `clk`.
- `dout` output, DBIT: last received byte; updated only together with `rx_done_tick`.
- `rx_done_tick` output, 1: one-cycle strobe marking a completed frame.
- `frame_err` output, 1: registered, valid with `rx_done_tick`; 1 = stop bit sampled low.
- `parity_err` output, 1: present only with `UART_RX_PARITY_EN`.

## Operation
- **Input synchroniser.** `rx` passes through a 2-FF synchroniser. Both flops reset to 1. All FSM decisions use the synchronised value `rx_s`.
- **Internal registers.**
  - `s_cnt`: tick counter, width clog2(max(OVS, SB_TICK)).
  - `n_cnt`: bit counter, width clog2(DBIT).
  - `b_reg`: DBIT shift register.
- **FSM states.** IDLE, START, DATA, PARITY (macro only), STOP.
  - **IDLE.** If `rx_s`==0: clear `s_cnt`, go to START. `s_tick` is not required to leave IDLE.
  - **START.** On each `s_tick`, increment `s_cnt`. When `s_cnt`==OVS/2-1 with `s_tick`:
    - if `rx_s`==0: clear `s_cnt` and `n_cnt`, go to DATA;
    - else (glitch): go to IDLE.
  - **DATA.** On each `s_tick`, increment `s_cnt`. When `s_cnt`==OVS-1 with `s_tick` (mid-bit):
    - `b_reg` ← {`rx_s`, `b_reg`[DBIT-1:1]} (LSB-first), and `s_cnt` ← 0;
    - if `n_cnt`==DBIT-1, go to STOP (or PARITY); else `n_cnt`+1.
  - **PARITY.** Same mid-bit sample as DATA. Store `rx_s` XOR (XOR of `b_reg`) as the pending parity error (even parity). Go to STOP.
  - **STOP.** On each `s_tick`, increment `s_cnt`. When `s_cnt`==SB_TICK-1 with `s_tick`:
    - `dout` ← `b_reg`;
    - `frame_err` ← ~`rx_s`;
    - `rx_done_tick` ← 1;
    - go to IDLE.
- **Outputs.** `dout`, `frame_err` and `parity_err` hold their values until the next done strobe.
- **Error frames.** A frame with a framing error still updates `dout`. No resynchronisation or hunting occurs; if `rx_s` is already low on return to IDLE, the next frame starts immediately.
- **Ticks in IDLE.** `s_tick` pulses while in IDLE are ignored.
- **Absent tick.** With `s_tick` held low, the FSM freezes in its current state indefinitely.

## Timing
- **Reset values.** `dout`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0, state=IDLE, counters=0, synchroniser flops=1.
- **Reset mid-frame.** Aborts immediately. No strobe is issued; outputs return to their reset values.
- **Start latency.** IDLE→START occurs 2 clocks after the falling `rx` edge (synchroniser) plus 1 clock.
- **Done strobe.** `rx_done_tick` is a registered output. It asserts in the clock cycle after the final stop `s_tick` and lasts exactly 1 clock.
- **Frame duration.** The strobe occurs (OVS/2 + DBIT·OVS + SB_TICK) ticks after start detection. That is 152 ticks for the defaults, or 168 with parity.
- **Glitch rejection.** A low pulse on `rx` shorter than OVS/2 ticks returns the FSM to IDLE with no strobe.
- **Tolerance.** Sampling is at mid-bit. Frames are received correctly with up to ±4% baud mismatch at the defaults.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - PARITY state compiled in; one even-parity bit is expected between the data bits and the stop bit;
  - `parity_err` port exists, registered, updated with `rx_done_tick`, reset value 0.
- **`UART_RX_PARITY_EN` undefined:**
  - no PARITY state and no `parity_err` port;
  - the frame is 8N1 and DATA goes directly to STOP.

## Test plan
- **Reset.** Assert `rst` mid-idle. Required: `dout`=0x00, `rx_done_tick`=0, `frame_err`=0.
- **Basic frame.** `s_tick` every 4 clks, OVS=16. Drive 0x55, then 0xA3, LSB-first, 64 clks per bit. Required:
  - exactly one `rx_done_tick` per frame;
  - `dout`=0x55 then 0xA3;
  - `frame_err`=0;
  - strobe 152 ticks after the start edge.
- **Glitch.** Low pulse of 5 ticks while idle. Required: no strobe, FSM back to IDLE, `dout` unchanged.
- **Framing error.** Send 0xFF with the stop bit held low. Required: `rx_done_tick`=1 with `dout`=0xFF and `frame_err`=1.
- **Reset mid-frame.** Assert `rst` after bit 3 of 0x3C, then send 0xC3. Required: no strobe for the aborted frame; next strobe has `dout`=0xC3.
- **Parity (`UART_RX_PARITY_EN`).** Send 0x07 with parity bit 1. Required: `parity_err`=0. Send 0x07 with parity bit 0. Required: `parity_err`=1.

Source files
------------

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : Oversampling 8N1 UART receiver driven by an OVS x baud sample tick.
//            The optional even-parity bit is enabled by the UART_RX_PARITY_EN macro.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            frame_err
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] c_HALF  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] c_FULL  = SW'(OVS - 1);
  localparam logic [SW-1:0] c_STOP  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] c_NLAST = NW'(DBIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] c_AFTER_DATA = S_PAR;
`else
  localparam logic [2:0] c_AFTER_DATA = S_STOP;
`endif

  logic [2:0]      r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [SW-1:0]   r_s_cnt;
  logic [NW-1:0]   r_n_cnt;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_fe;
  logic            w_rx_s;
`ifdef UART_RX_PARITY_EN
  logic            r_perr_pend;
  logic            r_perr;

  assign parity_err = r_perr;
`endif

  assign w_rx_s       = r_sync2;
  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_fe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_fe    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_pend <= 1'b0;
      r_perr      <= 1'b0;
`endif
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Start detection is tick-independent so the half-bit count begins at once.
          if (!w_rx_s) begin
            r_s_cnt <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (s_tick) begin
            if (r_s_cnt == c_HALF) begin
              if (!w_rx_s) begin
                r_s_cnt <= '0;
                r_n_cnt <= '0;
                r_state <= S_DATA;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (s_tick) begin
            if (r_s_cnt == c_FULL) begin
              r_b     <= {w_rx_s, r_b[DBIT-1:1]};
              r_s_cnt <= '0;
              if (r_n_cnt == c_NLAST) begin
                r_state <= c_AFTER_DATA;
              end else begin
                r_n_cnt <= r_n_cnt + 1'b1;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          if (s_tick) begin
            if (r_s_cnt == c_FULL) begin
              r_perr_pend <= w_rx_s ^ (^r_b);
              r_s_cnt     <= '0;
              r_state     <= S_STOP;
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (s_tick) begin
            if (r_s_cnt == c_STOP) begin
              r_dout  <= r_b;
              r_fe    <= ~w_rx_s;
              r_done  <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_perr  <= r_perr_pend;
`endif
              r_state <= S_IDLE;
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx (tick every 4 clocks, 64 clocks per bit).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CLK_NS = 10;
  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_TICKS = 168;
`else
  localparam int FRAME_TICKS = 152;
`endif
  // Strobe is seen on the falling edge half a clock after the final tick edge.
  localparam int LAT_NS = FRAME_TICKS * 4 * CLK_NS + CLK_NS / 2;

  logic       clk;
  logic       rst;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  int   checks;
  int   errors;
  int   done_cnt;
  int   exp_done;
  logic [7:0] last_dout;
  logic last_fe;
  logic last_pe;
  time  t0;
  time  t_done;

  uart_rx #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .frame_err    (frame_err)
  );

`ifndef UART_RX_PARITY_EN
  initial parity_err = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #(CLK_NS / 2) clk = ~clk;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) begin
        done_cnt++;
        last_dout = dout;
        last_fe   = frame_err;
        last_pe   = parity_err;
        t_done    = $time;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Launch the start bit right after the edge that samples a tick.
  task automatic start_bit();
    @(negedge clk);
    while (s_tick !== 1'b1) @(negedge clk);
    @(posedge clk);
    t0 = $time;
    #1 rx = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_low);
    start_bit();
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_bit;
    wait_clks(BIT_CLKS);
`else
    if (par_bit === 1'bx) rx = 1'b1;
`endif
    if (stop_low) begin
      rx = 1'b0;
      wait_clks(40);
      rx = 1'b1;
      wait_clks(BIT_CLKS - 40);
    end else begin
      rx = 1'b1;
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp_d, input logic exp_fe);
    exp_done++;
    check({tag, "_done_cnt"}, done_cnt, exp_done);
    check({tag, "_dout"}, {24'd0, last_dout}, {24'd0, exp_d});
    check({tag, "_frame_err"}, {31'd0, last_fe}, {31'd0, exp_fe});
    check({tag, "_latency_ns"}, 32'(t_done - t0), LAT_NS);
  endtask

  initial begin
    logic [7:0] d;
    checks   = 0;
    errors   = 0;
    exp_done = 0;
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(50);

    rst = 1'b1;
    #1;
    check("rst_dout", {24'd0, dout}, 32'h00);
    check("rst_done", {31'd0, rx_done_tick}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(50);

    send_frame(8'h55, 1'b0, 1'b0);
    check_frame("f55", 8'h55, 1'b0);
    wait_clks(100);
    send_frame(8'hA3, 1'b0, 1'b0);
    check_frame("fA3", 8'hA3, 1'b0);
    wait_clks(100);

    start_bit();
    wait_clks(20);
    rx = 1'b1;
    wait_clks(300);
    check("glitch_no_strobe", done_cnt, exp_done);
    check("glitch_dout_kept", {24'd0, dout}, 32'hA3);

    send_frame(8'h5A, 1'b0, 1'b0);
    check_frame("f5A_after_glitch", 8'h5A, 1'b0);
    wait_clks(100);

    send_frame(8'hFF, 1'b0, 1'b1);
    check_frame("fFF_frame_err", 8'hFF, 1'b1);
    check("frame_err_held", {31'd0, frame_err}, 32'd1);
    wait_clks(300);
    check("frame_err_no_extra", done_cnt, exp_done);

    d = 8'h3C;
    start_bit();
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
    rst = 1'b1;
    #1;
    check("midrst_dout", {24'd0, dout}, 32'h00);
    check("midrst_done", {31'd0, rx_done_tick}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    wait_clks(3);
    rx  = 1'b1;
    rst = 1'b0;
    wait_clks(600);
    check("midrst_no_strobe", done_cnt, exp_done);
    send_frame(8'hC3, 1'b0, 1'b0);
    check_frame("fC3_after_rst", 8'hC3, 1'b0);
    wait_clks(100);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    check_frame("f07_par1", 8'h07, 1'b0);
    check("f07_par1_parity_err", {31'd0, last_pe}, 32'd0);
    wait_clks(100);
    send_frame(8'h07, 1'b0, 1'b0);
    check_frame("f07_par0", 8'h07, 1'b0);
    check("f07_par0_parity_err", {31'd0, last_pe}, 32'd1);
    wait_clks(100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
